gate_truth_sequencer: RTL and testbench

Self-checking controller for a 2-input combinational gate such as the board's AND gate. It steps the gate inputs a/b through all four combinations {a,b} = 00, 01, 10, 11. For each vector it waits a settle time, samples the gate output and compares it against a parameterised truth table. It reports per-vector failures, an error count and pass/done status, so the gate can be exercised on the EDU-CIAA board without a host.

---
 rtl/gate_truth_sequencer.sv | 95 +++++++++
 tb/tb_gate_truth_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_sequencer.sv
// Truth-table self-check sequencer for a 2-input combinational gate.
// Steps {a,b} through 00..11, settles each vector, samples s_i and accumulates mismatches.
//
// state  | meaning
// IDLE   | waiting for start|loop_en; results of the last run held
// SETTLE | vector applied, counting SETTLE_CYCLES for the gate to settle
// CHECK  | one cycle; s_i compared against TRUTH[vec_idx] on exit
module gate_truth_sequencer #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] TRUTH         = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       loop_en,
  output logic       a_o,
  output logic       b_o,
  input  logic       s_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_map,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic [1:0]    vec_next;

  assign mismatch = (s_i != TRUTH[vec_idx]);
  assign vec_next = vec_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      vec_idx   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_map  <= 4'd0;
      err_count <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done is high during this cycle after a run, so a restart lands one edge after it
          if (start | loop_en) begin
            vec_idx   <= 2'd0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            cnt       <= '0;
            fail_map  <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            fail_map[vec_idx] <= 1'b1;
            err_count         <= err_count + 3'd1;
          end
          if (vec_idx != 2'd3) begin
            vec_idx    <= vec_next;
            {a_o, b_o} <= vec_next;
            cnt        <= '0;
            state      <= SETTLE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 3'd0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Scoreboard bench for gate_truth_sequencer: a run-level model pushes expected results at
// start-accept, a negedge monitor pops them on done and checks timing/outputs every cycle.
module tb_gate_truth_sequencer;

  localparam int         S     = 4;
  localparam logic [3:0] TRUTH = 4'b1000;
  localparam int         RUN   = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic       a_o, b_o, s_i, busy, done, pass;
  logic [3:0] fail_map;
  logic [2:0] err_count;
  logic [1:0] vec_idx;
  logic [3:0] gate_fn = 4'b1000;

  // gate under test modelled as an arbitrary 2-input truth table
  assign s_i = gate_fn[{a_o, b_o}];

  gate_truth_sequencer #(.SETTLE_CYCLES(S), .TRUTH(TRUTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en),
    .a_o(a_o), .b_o(b_o), .s_i(s_i), .busy(busy), .done(done), .pass(pass),
    .fail_map(fail_map), .err_count(err_count), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] fm;
    logic [2:0] ec;
    logic       ps;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t held = '0;
  bit   m_busy = 0;
  bit   m_done = 0;
  int   m_t = 0;
  logic [1:0] m_vec = 2'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic res_t expect_of(input logic [3:0] g);
    res_t r;
    r.fm = g ^ TRUTH;
    r.ec = 3'($countones(r.fm));
    r.ps = (r.fm == 4'd0);
    return r;
  endfunction

  // run-level reference: a run is RUN edges long, vector k occupies edges k*(S+1)..k*(S+1)+S
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_t = 0; m_vec = 2'd0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_t++;
        if (m_t == RUN) begin
          m_busy = 0; m_done = 1; m_vec = 2'd3;
        end else begin
          m_vec = 2'(m_t / (S + 1));
        end
      end else if (start | loop_en) begin
        m_busy = 1; m_t = 0; m_vec = 2'd0;
        exp_q.push_back(expect_of(gate_fn));
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
      held = '0;
    end else begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("vec_idx", vec_idx, m_vec);
      check("ab", {a_o, b_o}, m_vec);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected got 1 exp 0 at %0t", $time);
        end else begin
          r = exp_q.pop_front();
          check("fail_map", fail_map, r.fm);
          check("err_count", err_count, r.ec);
          check("pass", pass, r.ps);
          held = r;
        end
      end
      if (m_busy) begin
        check("pass_in_run", pass, 0);
        if (m_t == 0) begin
          check("fail_map_clr", fail_map, 0);
          check("err_count_clr", err_count, 0);
        end
      end else begin
        check("fail_map_hold", fail_map, held.fm);
        check("err_count_hold", err_count, held.ec);
        check("pass_hold", pass, held.ps);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_map"}, fail_map, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_vec_idx"}, vec_idx, 0);
    check({tag, "_ab"}, {a_o, b_o}, 0);
  endtask

  task automatic run_gate(input logic [3:0] g);
    @(negedge clk);
    gate_fn = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RUN + 3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AND, stuck-0, stuck-1, NAND, XOR against the AND table
    run_gate(4'b1000);
    run_gate(4'b0000);
    run_gate(4'b1111);
    run_gate(4'b0111);
    run_gate(4'b0110);

    // start re-pulsed during vector 2 must be ignored
    gate_fn = 4'b1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RUN) @(negedge clk);

    // start held: back-to-back runs with failing results cleared on each accept
    gate_fn = 4'b1111;
    start = 1'b1;
    repeat (2 * RUN + 2) @(negedge clk);
    start = 1'b0;
    repeat (RUN + 5) @(negedge clk);

    // async reset during SETTLE of vector 01
    gate_fn = 4'b1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // free-running loop, then loop_en dropped mid-run
    gate_fn = 4'b0110;
    loop_en = 1'b1;
    repeat (3 * (RUN + 1) + 8) @(negedge clk);
    loop_en = 1'b0;
    repeat (RUN + 5) @(negedge clk);

    // random gate functions with random start timing and pulse width
    for (int i = 0; i < 15; i++) begin
      gate_fn = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
      repeat (RUN + 3) @(negedge clk);
    end

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_runs got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
